// File: rtl/pfb_reorder_buffer_if.sv
// Sample stream bundle between the PFB lane, the reorder buffer and the FFT core.
// The slave modport is the reorder buffer's view of the bundle.
interface pfb_reorder_buffer_if #(
  parameter int DIN_WIDTH = 18
);
  logic signed [DIN_WIDTH-1:0] din;
  logic                        din_valid;
  logic                        sync_in;
  logic signed [DIN_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        sync_out;
  logic                        dout_last;
  logic                        sync_err;

  modport master (
    output din, din_valid, sync_in,
    input  dout, dout_valid, sync_out, dout_last, sync_err
  );

  modport slave (
    input  din, din_valid, sync_in,
    output dout, dout_valid, sync_out, dout_last, sync_err
  );
endinterface

// File: rtl/pfb_reorder_buffer.sv
// Ping-pong frame buffer feeding the FFT: aligns frames on sync_in and emits each one as a burst.
// Define REORDER_BITREV_EN for bit-reversed output order; otherwise the output is in natural order.
module pfb_reorder_buffer #(
  parameter int DIN_WIDTH = 18,
  parameter int PFB_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pfb_reorder_buffer_if.slave  bus
);

  localparam int            AW       = $clog2(PFB_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(PFB_SIZE - 1);

  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_READ} r_state_t;

  // Two banks in one array; address MSB selects the bank.
  logic signed [DIN_WIDTH-1:0] mem [2*PFB_SIZE];

  w_state_t      w_state_reg, w_state_next;
  logic [AW-1:0] wcnt_reg, wcnt_next;
  logic          wbank_reg, wbank_next;
  logic          sync_err_reg, sync_err_next;
  logic          we;
  logic [AW-1:0] waddr;
  logic          frame_done;

  r_state_t      r_state_reg, r_state_next;
  logic [AW-1:0] rcnt_reg, rcnt_next;
  logic          rbank_reg, rbank_next;
  logic          pend_reg, pend_next;
  logic          pend_bank_reg, pend_bank_next;
  logic          pend_clr;
  logic          rd_en;
  logic [AW-1:0] raddr;

  logic signed [DIN_WIDTH-1:0] dout_reg;
  logic          dout_valid_reg, sync_out_reg, dout_last_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg   <= W_IDLE;
      wcnt_reg      <= '0;
      wbank_reg     <= 1'b0;
      sync_err_reg  <= 1'b0;
      r_state_reg   <= R_IDLE;
      rcnt_reg      <= '0;
      rbank_reg     <= 1'b0;
      pend_reg      <= 1'b0;
      pend_bank_reg <= 1'b0;
    end else begin
      w_state_reg   <= w_state_next;
      wcnt_reg      <= wcnt_next;
      wbank_reg     <= wbank_next;
      sync_err_reg  <= sync_err_next;
      r_state_reg   <= r_state_next;
      rcnt_reg      <= rcnt_next;
      rbank_reg     <= rbank_next;
      pend_reg      <= pend_next;
      pend_bank_reg <= pend_bank_next;
    end
  end

  always_comb begin
    w_state_next  = w_state_reg;
    wcnt_next     = wcnt_reg;
    wbank_next    = wbank_reg;
    sync_err_next = 1'b0;
    we            = 1'b0;
    waddr         = wcnt_reg;
    frame_done    = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (bus.din_valid && bus.sync_in) begin
          we           = 1'b1;
          waddr        = '0;
          wcnt_next    = AW'(1);
          w_state_next = W_FILL;
        end
      end
      W_FILL: begin
        if (bus.din_valid) begin
          we = 1'b1;
          if (bus.sync_in && (wcnt_reg != '0)) begin
            // Sync arrived mid-frame: drop the partial frame and restart this bank.
            waddr         = '0;
            wcnt_next     = AW'(1);
            sync_err_next = 1'b1;
          end else begin
            wcnt_next = wcnt_reg + AW'(1);
            if (wcnt_reg == LAST_IDX) begin
              frame_done = 1'b1;
              wbank_next = ~wbank_reg;
            end
          end
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next   = r_state_reg;
    rcnt_next      = rcnt_reg;
    rbank_next     = rbank_reg;
    pend_clr       = 1'b0;
    rd_en          = (r_state_reg == R_READ);
    case (r_state_reg)
      R_IDLE: begin
        if (pend_reg) begin
          r_state_next = R_READ;
          rcnt_next    = '0;
          rbank_next   = pend_bank_reg;
          pend_clr     = 1'b1;
        end
      end
      R_READ: begin
        rcnt_next = rcnt_reg + AW'(1);
        if (rcnt_reg == LAST_IDX) begin
          if (pend_reg) begin
            rbank_next = pend_bank_reg;
            pend_clr   = 1'b1;
          end else begin
            r_state_next = R_IDLE;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
    // Input rate guarantees the pending slot is empty whenever a new frame completes.
    pend_next      = pend_reg & ~pend_clr;
    pend_bank_next = pend_bank_reg;
    if (frame_done) begin
      pend_next      = 1'b1;
      pend_bank_next = wbank_reg;
    end
  end

  genvar gi;
`ifdef REORDER_BITREV_EN
  generate
    for (gi = 0; gi < AW; gi++) begin : g_bitrev
      assign raddr[gi] = rcnt_reg[AW-1-gi];
    end
  endgenerate
`else
  assign raddr = rcnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbank_reg, waddr}] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      sync_out_reg   <= 1'b0;
      dout_last_reg  <= 1'b0;
    end else begin
      dout_valid_reg <= rd_en;
      sync_out_reg   <= rd_en && (rcnt_reg == '0);
      dout_last_reg  <= rd_en && (rcnt_reg == LAST_IDX);
      if (rd_en) begin
        dout_reg <= mem[{rbank_reg, raddr}];
      end
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.sync_out   = sync_out_reg;
  assign bus.dout_last  = dout_last_reg;
  assign bus.sync_err   = sync_err_reg;

endmodule

// File: tb/tb_pfb_reorder_buffer.sv
// Directed bench for pfb_reorder_buffer with PFB_SIZE=8; expected order follows REORDER_BITREV_EN.
// Outputs are collected at the falling edge and compared against hand-derived frames.
module tb_pfb_reorder_buffer;

  localparam int DW = 18;
  localparam int N  = 8;

  typedef struct {
    int cyc;
    int data;
    bit so;
    bit lst;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   err_cnt = 0;
  int   last_edge = 0;
  out_t q[$];

  pfb_reorder_buffer_if #(.DIN_WIDTH(DW)) bus ();

  pfb_reorder_buffer #(.DIN_WIDTH(DW), .PFB_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      out_t e;
      e.cyc  = cyc;
      e.data = int'(bus.dout);
      e.so   = bus.sync_out;
      e.lst  = bus.dout_last;
      q.push_back(e);
    end
    if (bus.sync_err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int ord(input int i);
    int r;
`ifdef REORDER_BITREV_EN
    r = {i[0], i[1], i[2]};
`else
    r = i;
`endif
    return r;
  endfunction

  task automatic put(input bit v, input bit s, input int d);
    bus.din_valid = v;
    bus.sync_in   = s;
    bus.din       = DW'(d);
    @(posedge clk);
    #1;
    if (v) last_edge = cyc;
    bus.din_valid = 1'b0;
    bus.sync_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    q.delete();
    err_cnt = 0;
  endtask

  // Expects nfr contiguous frames; frame f entry j = base + 8f + ord(j).
  task automatic verify_burst(input string tag, input int base, input int nfr, input int fe);
    int n;
    n = q.size();
    check_eq({tag, "_len"}, n, N * nfr);
    if (n > 0) check_eq({tag, "_latency"}, q[0].cyc, fe + 2);
    for (int i = 0; i < n && i < N * nfr; i++) begin
      int j;
      int f;
      j = i % N;
      f = i / N;
      check_eq($sformatf("%s_data%0d", tag, i), q[i].data, base + f * N + ord(j));
      check_eq($sformatf("%s_cyc%0d", tag, i), q[i].cyc, q[0].cyc + i);
      check_eq($sformatf("%s_flags%0d", tag, i), int'({q[i].so, q[i].lst}),
               ((j == 0) ? 2 : 0) | ((j == N - 1) ? 1 : 0));
    end
  endtask

  initial begin
    int fe;
    int nsync;
    rst = 1'b1;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.sync_in = 1'b0;
    idle(3);
    check_eq("rst_dout", int'(bus.dout), 0);
    check_eq("rst_valid", int'(bus.dout_valid), 0);
    check_eq("rst_sync_out", int'(bus.sync_out), 0);
    check_eq("rst_last", int'(bus.dout_last), 0);
    check_eq("rst_sync_err", int'(bus.sync_err), 0);
    rst = 1'b0;

    // Single frame, continuous ramp.
    clear();
    put(1, 1, 0);
    for (int i = 1; i < N; i++) put(1, 0, i);
    fe = last_edge;
    idle(20);
    verify_burst("s1", 0, 1, fe);
    check_eq("s1_err", err_cnt, 0);
    $display("s1 single frame: %0d outputs", q.size());

    // Four back-to-back frames from one sync.
    clear();
    fe = 0;
    put(1, 1, 0);
    for (int i = 1; i < 4 * N; i++) begin
      put(1, 0, i);
      if (i == N - 1) fe = last_edge;
    end
    idle(20);
    verify_burst("s2", 0, 4, fe);
    nsync = 0;
    foreach (q[i]) if (q[i].so) nsync++;
    check_eq("s2_syncs", nsync, 4);
    check_eq("s2_err", err_cnt, 0);
    $display("s2 four frames: %0d outputs", q.size());

    // Half-rate input still yields a contiguous burst.
    clear();
    for (int i = 0; i < N; i++) begin
      put(1, i == 0, i);
      put(0, 0, 0);
    end
    idle(20);
    verify_burst("s3", 0, 1, last_edge);
    $display("s3 half rate: %0d outputs", q.size());

    // Mid-frame resync discards the partial frame.
    clear();
    put(1, 1, 0);
    for (int i = 1; i < 5; i++) put(1, 0, i);
    put(1, 1, 100);
    for (int i = 1; i < N; i++) put(1, 0, 100 + i);
    fe = last_edge;
    idle(20);
    verify_burst("s4", 100, 1, fe);
    check_eq("s4_err", err_cnt, 1);
    $display("s4 resync: %0d outputs, %0d sync errors", q.size(), err_cnt);

    // Reset during an output burst.
    clear();
    put(1, 1, 0);
    for (int i = 1; i < N; i++) put(1, 0, i);
    for (int k = 0; k < 20; k++) begin
      if (q.size() >= 3) break;
      @(posedge clk);
      #1;
    end
    check_eq("s5_burst_seen", int'(q.size() >= 3), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("s5_rst_dout", int'(bus.dout), 0);
    check_eq("s5_rst_valid", int'(bus.dout_valid), 0);
    check_eq("s5_rst_sync_out", int'(bus.sync_out), 0);
    check_eq("s5_rst_last", int'(bus.dout_last), 0);
    clear();
    for (int i = 0; i < N + 4; i++) put(1, 0, i);
    idle(20);
    check_eq("s5_nosync_quiet", q.size(), 0);
    clear();
    put(1, 1, 50);
    for (int i = 1; i < N; i++) put(1, 0, 50 + i);
    fe = last_edge;
    idle(20);
    verify_burst("s5", 50, 1, fe);
    $display("s5 reset recovery: %0d outputs", q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
